// File: rtl/stream_odd_even_sort.sv
// Streaming block sorter: loads DATA_N elements, runs DATA_N odd-even
// transposition phases on a shared compare-exchange bank, then drains the
// block in descending order (largest first) on a valid/ready output.
module stream_odd_even_sort #(
  parameter int unsigned DATA_N = 4,
  parameter int unsigned DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DATA_N + 1);
  localparam int unsigned IDX_W = $clog2(DATA_N);
  localparam int unsigned CX_N  = DATA_N / 2;
  localparam int          N_I   = int'(DATA_N);
  localparam int          CX_I  = int'(CX_N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_N - 1);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_SORT,
    ST_DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  phase_cnt_q, phase_cnt_d;
  logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] slot_q [DATA_N];
  logic [DATA_W-1:0] slot_d [DATA_N];

  logic              s_ready_q, s_ready_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_last_q, m_last_d;
  logic              busy_q, busy_d;

  // Compare-exchange bank signals
  logic              phase_odd;
  logic              cx_en [CX_N];
  logic [DATA_W-1:0] cx_a  [CX_N];
  logic [DATA_W-1:0] cx_b  [CX_N];
  logic [DATA_W-1:0] cx_hi [CX_N];
  logic [DATA_W-1:0] cx_lo [CX_N];
  logic [DATA_W-1:0] cx_slot [DATA_N];

  assign phase_odd = phase_cnt_q[0];

  // Route slot pairs onto the shared units: even phase (2k,2k+1), odd phase (2k+1,2k+2)
  always_comb begin
    for (int k = 0; k < CX_I; k++) begin
      cx_en[k] = 1'b0;
      cx_a[k]  = '0;
      cx_b[k]  = '0;
      if (!phase_odd) begin
        cx_en[k] = 1'b1;
        cx_a[k]  = slot_q[2*k];
        cx_b[k]  = slot_q[2*k+1];
      end else if (2*k + 2 < N_I) begin
        cx_en[k] = 1'b1;
        cx_a[k]  = slot_q[2*k+1];
        cx_b[k]  = slot_q[(2*k + 2 < N_I) ? 2*k+2 : N_I-1];
      end
    end
  end

  // Each unit swaps only on a strictly larger right element, so ties keep their order
  always_comb begin
    for (int k = 0; k < CX_I; k++) begin
      if (cx_b[k] > cx_a[k]) begin
        cx_hi[k] = cx_b[k];
        cx_lo[k] = cx_a[k];
      end else begin
        cx_hi[k] = cx_a[k];
        cx_lo[k] = cx_b[k];
      end
    end
  end

  // Write unit results back to their slots; unpaired slots pass through
  always_comb begin
    for (int i = 0; i < N_I; i++) begin
      cx_slot[i] = slot_q[i];
      if (!phase_odd) begin
        if (i / 2 < CX_I) begin
          cx_slot[i] = (i % 2 == 0) ? cx_hi[(i/2 < CX_I) ? i/2 : CX_I-1]
                                    : cx_lo[(i/2 < CX_I) ? i/2 : CX_I-1];
        end
      end else if (i > 0 && (i - 1) / 2 < CX_I) begin
        if (cx_en[((i-1)/2 < CX_I) ? (i-1)/2 : CX_I-1]) begin
          cx_slot[i] = (i % 2 == 1) ? cx_hi[((i-1)/2 < CX_I) ? (i-1)/2 : CX_I-1]
                                    : cx_lo[((i-1)/2 < CX_I) ? (i-1)/2 : CX_I-1];
        end
      end
    end
  end

  // FSM next state, counters and slot updates
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    phase_cnt_d = phase_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    slot_d      = slot_q;
    unique case (state_q)
      ST_LOAD: begin
        if (s_valid && s_ready_q) begin
          slot_d[wr_cnt_q[IDX_W-1:0]] = s_data;
          if (wr_cnt_q == LAST) begin
            state_d     = ST_SORT;
            wr_cnt_d    = '0;
            phase_cnt_d = '0;
          end else begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_SORT: begin
        slot_d = cx_slot;
        if (phase_cnt_q == LAST) begin
          state_d     = ST_DRAIN;
          phase_cnt_d = '0;
          rd_ptr_d    = '0;
        end else begin
          phase_cnt_d = phase_cnt_q + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (m_valid_q && m_ready) begin
          if (rd_ptr_q == LAST) begin
            state_d  = ST_LOAD;
            rd_ptr_d = '0;
          end else begin
            rd_ptr_d = rd_ptr_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // Output values for the next cycle, decoded from the next state
  always_comb begin
    s_ready_d = 1'b0;
    busy_d    = 1'b0;
    m_valid_d = 1'b0;
    m_data_d  = '0;
    m_last_d  = 1'b0;
    unique case (state_d)
      ST_LOAD:  s_ready_d = 1'b1;
      ST_SORT:  busy_d    = 1'b1;
      ST_DRAIN: begin
        busy_d    = 1'b1;
        m_valid_d = 1'b1;
        m_data_d  = slot_d[rd_ptr_d[IDX_W-1:0]];
        m_last_d  = (rd_ptr_d == LAST);
      end
      default: s_ready_d = 1'b0;
    endcase
  end

  // State, counter, slot and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      wr_cnt_q    <= '0;
      phase_cnt_q <= '0;
      rd_ptr_q    <= '0;
      for (int i = 0; i < N_I; i++) begin
        slot_q[i] <= '0;
      end
      s_ready_q   <= 1'b1;
      busy_q      <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      phase_cnt_q <= phase_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      slot_q      <= slot_d;
      s_ready_q   <= s_ready_d;
      busy_q      <= busy_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
    end
  end

  assign s_ready = s_ready_q;
  assign busy    = busy_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;

endmodule

// File: tb/tb_stream_odd_even_sort.sv
// Bench for stream_odd_even_sort: a DATA_N=4 and a DATA_N=5 instance share
// the stimulus; sel picks which one is active. Expected outputs come from a
// hand-written table and from a queue-sort reference model.
module tb_stream_odd_even_sort;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sel;
  logic       s_valid;
  logic [3:0] s_data;
  logic       m_ready;

  logic       s_ready4, m_valid4, m_last4, busy4;
  logic [3:0] m_data4;
  logic       s_ready5, m_valid5, m_last5, busy5;
  logic [3:0] m_data5;

  logic       s_ready, m_valid, m_last, busy;
  logic [3:0] m_data;

  int checks = 0;
  int errors = 0;
  int in_q[$];
  int exp_q[$];

  typedef struct {
    int n;
    int din [5];
    int dout[5];
    int mode;
    bit noise;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  stream_odd_even_sort #(.DATA_N(4), .DATA_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid && !sel), .s_ready(s_ready4), .s_data(s_data),
    .m_valid(m_valid4), .m_ready(m_ready && !sel), .m_data(m_data4),
    .m_last(m_last4), .busy(busy4)
  );

  stream_odd_even_sort #(.DATA_N(5), .DATA_W(4)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid && sel), .s_ready(s_ready5), .s_data(s_data),
    .m_valid(m_valid5), .m_ready(m_ready && sel), .m_data(m_data5),
    .m_last(m_last5), .busy(busy5)
  );

  assign s_ready = sel ? s_ready5 : s_ready4;
  assign m_valid = sel ? m_valid5 : m_valid4;
  assign m_data  = sel ? m_data5  : m_data4;
  assign m_last  = sel ? m_last5  : m_last4;
  assign busy    = sel ? busy5    : busy4;

  task automatic chk(input string name, input int got, input int exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp_v, $time);
    end
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_s_ready"}, int'(s_ready), 1);
    chk({tag, "_m_valid"}, int'(m_valid), 0);
    chk({tag, "_m_data"},  int'(m_data),  0);
    chk({tag, "_m_last"},  int'(m_last),  0);
    chk({tag, "_busy"},    int'(busy),    0);
  endtask

  task automatic add_vec(input int n, input int d0, input int d1, input int d2,
                         input int d3, input int d4, input int e0, input int e1,
                         input int e2, input int e3, input int e4,
                         input int mode, input bit noise);
    vec_t v;
    v.n = n;
    v.din[0] = d0; v.din[1] = d1; v.din[2] = d2; v.din[3] = d3; v.din[4] = d4;
    v.dout[0] = e0; v.dout[1] = e1; v.dout[2] = e2; v.dout[3] = e3; v.dout[4] = e4;
    v.mode = mode;
    v.noise = noise;
    vecs.push_back(v);
  endtask

  // Pulse reset starting at a negedge; both instances return to an idle LOAD state
  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    idle_checks(tag);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Feed n elements of in_q; returns at the negedge right after the last accept
  task automatic send_block(input int n, input bit gaps);
    int w;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          s_valid = 1'b0;
          @(posedge clk);
          @(negedge clk);
        end
      end
      s_valid = 1'b1;
      s_data  = 4'(in_q[i]);
      w = 0;
      while (!s_ready && w < 50) begin
        @(posedge clk);
        @(negedge clk);
        w++;
      end
      if (!s_ready) begin
        chk("s_ready_timeout", 0, 1);
        s_valid = 1'b0;
        return;
      end
      @(posedge clk);
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  // Check latency, then drain against exp_q; mode 0=ready, 1=1,0,0,1 pattern, 2=random
  task automatic collect(input int n, input int mode, input bit noise);
    int  lat;
    int  idx;
    int  c;
    bit  rdy;
    lat = 0;
    for (int cnt = 1; cnt <= 4 * n + 8 && lat == 0; cnt++) begin
      if (noise) begin
        s_valid = 1'b1;
        s_data  = 4'hf;
      end
      if (cnt == 1) begin
        chk("busy_in_sort", int'(busy), 1);
        chk("s_ready_in_sort", int'(s_ready), 0);
      end
      if (m_valid) begin
        lat = cnt;
      end else begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    chk("latency", lat, n + 1);
    if (lat == 0) begin
      s_valid = 1'b0;
      return;
    end
    idx = 0;
    c   = 0;
    while (idx < n && c < 20 * n + 20) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (c % 4 == 0) || (c % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      m_ready = rdy;
      if (noise && rdy && idx == n - 1) s_valid = 1'b0;
      chk("m_valid", int'(m_valid), 1);
      chk("m_data", int'(m_data), exp_q[idx]);
      chk("m_last", int'(m_last), (idx == n - 1) ? 1 : 0);
      if (rdy) idx++;
      c++;
      @(posedge clk);
      @(negedge clk);
    end
    if (idx < n) chk("drain_timeout", idx, n);
    s_valid = 1'b0;
    m_ready = 1'b0;
    idle_checks("after_drain");
  endtask

  task automatic load_model(input int n);
    in_q.delete();
    for (int i = 0; i < n; i++) in_q.push_back(int'($urandom_range(0, 15)));
    exp_q = in_q;
    exp_q.rsort();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    sel     = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;

    add_vec(4, 3, 1, 4, 2, 0,   4, 3, 2, 1, 0,    0, 1'b0);
    add_vec(4, 5, 5, 2, 5, 0,   5, 5, 5, 2, 0,    0, 1'b0);
    add_vec(4, 9, 7, 3, 0, 0,   9, 7, 3, 0, 0,    0, 1'b0);
    add_vec(4, 1, 2, 3, 4, 0,   4, 3, 2, 1, 0,    1, 1'b1);
    add_vec(4, 0, 0, 0, 1, 0,   1, 0, 0, 0, 0,    0, 1'b1);
    add_vec(5, 0, 15, 3, 15, 7, 15, 15, 7, 3, 0,  0, 1'b0);
    add_vec(5, 2, 2, 9, 1, 9,   9, 9, 2, 2, 1,    1, 1'b1);

    @(negedge clk);
    #1;
    idle_checks("reset4");
    sel = 1'b1;
    #1;
    idle_checks("reset5");
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[v]) begin
      sel = (vecs[v].n == 5);
      in_q.delete();
      exp_q.delete();
      for (int i = 0; i < vecs[v].n; i++) begin
        in_q.push_back(vecs[v].din[i]);
        exp_q.push_back(vecs[v].dout[i]);
      end
      send_block(vecs[v].n, 1'b0);
      collect(vecs[v].n, vecs[v].mode, vecs[v].noise);
      @(negedge clk);
    end

    // Reset in the second SORT cycle discards the block
    sel = 1'b0;
    in_q = '{8, 6, 7, 5};
    send_block(4, 1'b0);
    @(posedge clk);
    @(negedge clk);
    pulse_reset("rst_mid_sort");
    in_q = '{2, 9, 4, 1};
    exp_q = '{9, 4, 2, 1};
    send_block(4, 1'b0);
    collect(4, 0, 1'b0);

    // Reset part-way through LOAD: next accept must land in slot 0
    in_q = '{11, 12};
    send_block(2, 1'b0);
    pulse_reset("rst_mid_load");
    in_q = '{6, 14, 1, 10};
    exp_q = '{14, 10, 6, 1};
    send_block(4, 1'b0);
    collect(4, 2, 1'b0);

    // Reset after one DRAIN handshake
    in_q = '{3, 3, 8, 0};
    send_block(4, 1'b0);
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("drain_before_rst", int'(m_valid), 1);
    m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_ready = 1'b0;
    pulse_reset("rst_mid_drain");
    in_q = '{7, 13, 13, 2};
    exp_q = '{13, 13, 7, 2};
    send_block(4, 1'b0);
    collect(4, 1, 1'b0);

    // Random regression against the queue-sort model
    for (int blk = 0; blk < 1500; blk++) begin
      sel = (blk >= 1000);
      load_model(sel ? 5 : 4);
      send_block(sel ? 5 : 4, 1'b1);
      collect(sel ? 5 : 4, 2, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
